// File: rtl/dispense_decoder_if.sv
// Request channel of the dispense decoder: product index offered over valid/ready, plus a cancel line.
// The controller side drives the request and abort; the decoder side returns ready.
interface dispense_decoder_if #(
    parameter int N = 2
);
    logic         req_valid;
    logic [N-1:0] req_sel;
    logic         req_ready;
    logic         abort;

    modport master (
        output req_valid,
        output req_sel,
        output abort,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  abort,
        output req_ready
    );
endinterface

// File: rtl/dispense_decoder.sv
// Timed one-hot dispense decoder: IDLE -> ACTIVE (PULSE_CYCLES) -> GAP (GAP_CYCLES) -> IDLE.
// Optional saturating completed-dispense counter enabled by defining DISPENSE_CNT_EN.
module dispense_decoder #(
    parameter int N            = 2,
    parameter int NUM_ITEMS    = 2**N,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dispense_decoder_if.slave   req,
    output logic [2**N-1:0]     out,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef DISPENSE_CNT_EN
    ,
    output logic [CNT_W-1:0]    dispense_count
`endif
);

    localparam int W     = 2**N;
    localparam int MAX_T = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(MAX_T + 1);

    // Timers count down to zero, so they are loaded with length-1.
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [N:0]    ITEM_LIMIT = (N + 1)'(NUM_ITEMS);

    if (CNT_W < 1 || PULSE_CYCLES < 1 || GAP_CYCLES < 0 || NUM_ITEMS < 1 || NUM_ITEMS > W) begin : g_param_check
        $error("dispense_decoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [W-1:0]    out_reg,   out_next;
    logic            done_reg,  done_next;
    logic            err_reg,   err_next;
    logic [W-1:0]    sel_onehot;
    logic            sel_in_range;
    logic            accept;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_decode
            assign sel_onehot[gi] = (req.req_sel == N'(gi));
        end
    endgenerate

    assign sel_in_range  = ({1'b0, req.req_sel} < ITEM_LIMIT);
    assign req.req_ready = (state_reg == IDLE) && !req.abort;
    assign accept        = req.req_valid && req.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // out_next defaults to zero so the drive can only survive by being held in ACTIVE.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        out_next   = '0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (sel_in_range) begin
                        state_next = ACTIVE;
                        out_next   = sel_onehot;
                        timer_next = PULSE_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (req.abort) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer_reg == '0) begin
                    done_next = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        timer_next = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    out_next   = out_reg;
                    timer_next = timer_reg - TW'(1);
                end
            end
            GAP: begin
                if (req.abort || timer_reg == '0) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign out  = out_reg;
    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign err  = err_reg;

`ifdef DISPENSE_CNT_EN
    logic [CNT_W-1:0] count_reg, count_next;

    // Counts alongside the done pulse so the new value is visible while done is high.
    always_comb begin
        count_next = count_reg;
        if (done_next && (count_reg != {CNT_W{1'b1}}))
            count_next = count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign dispense_count = count_reg;
`endif

endmodule

// File: tb/tb_dispense_decoder.sv
// Scoreboard bench for dispense_decoder: a timeline model predicts each accepted request's response,
// and an independent negedge monitor pops and compares whenever the DUT produces a pulse or error.
module tb_dispense_decoder;

    localparam int N         = 2;
    localparam int W         = 4;
    localparam int NUM_ITEMS = 3;
    localparam int P         = 4;
    localparam int G         = 2;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         err;
`ifdef DISPENSE_CNT_EN
    logic [CNT_W-1:0] dispense_count;
`endif

    dispense_decoder_if #(.N(N)) ifc();

    dispense_decoder #(
        .N(N), .NUM_ITEMS(NUM_ITEMS), .PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (ifc),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .err   (err)
`ifdef DISPENSE_CNT_EN
        ,
        .dispense_count (dispense_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_err;
        int           e;
        logic [W-1:0] onehot;
        int           len;
        bit           exp_done;
        int           exp_count;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Model timeline: the DUT is idle in the cycle after edge t iff t >= free_edge.
    int free_edge     = 0;
    int plan_abort_t  = -100;
    int model_count   = 0;
    bit exp_ready_now = 1'b1;
    bit exp_busy_now  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drives one cycle, then folds an accepted request into the model.
    task automatic tick(input bit v, input int s, input int ab_off, input bit idle_abort);
        bit   ab;
        exp_t x;
        ab = (cyc == plan_abort_t) || (idle_abort && cyc >= free_edge);
        ifc.req_valid = v;
        ifc.req_sel   = 2'(s);
        ifc.abort     = ab;
        exp_busy_now  = (cyc < free_edge);
        exp_ready_now = (cyc >= free_edge) && !ab;
        @(posedge clk);
        #1;
        if (v && exp_ready_now) begin
            x.e         = cyc;
            x.is_err    = (s >= NUM_ITEMS);
            x.onehot    = '0;
            x.len       = 0;
            x.exp_done  = 1'b0;
            x.exp_count = model_count;
            if (!x.is_err) begin
                x.onehot = W'(1) << s;
                if (ab_off >= 0 && ab_off < P + G) begin
                    plan_abort_t = x.e + ab_off;
                    free_edge    = x.e + ab_off + 1;
                    x.len        = (ab_off < P) ? ab_off + 1 : P;
                    x.exp_done   = (ab_off >= P);
                end else begin
                    free_edge  = x.e + P + G;
                    x.len      = P;
                    x.exp_done = 1'b1;
                end
                if (x.exp_done) begin
                    model_count = (model_count < CNT_MAX) ? model_count + 1 : CNT_MAX;
                    x.exp_count = model_count;
                end
            end
            sb_q.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, -1, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
`ifdef DISPENSE_CNT_EN
        chk("rst_count", dispense_count, 0);
`endif
        sb_q.delete();
        model_count   = 0;
        plan_abort_t  = -100;
        free_edge     = 0;
        exp_ready_now = 1'b1;
        exp_busy_now  = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.abort     = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison group per DUT response, decoupled from the driver.
    exp_t cur;
    bit   mon_active = 1'b0;
    int   hi_cnt     = 0;

    always @(negedge clk) begin
        bit   ended;
        exp_t eo;
        ended = 1'b0;
        if (!rst_n) begin
            mon_active = 1'b0;
            hi_cnt     = 0;
        end else begin
            chk("req_ready", ifc.req_ready, exp_ready_now);
            chk("busy", busy, exp_busy_now);
            chk("out_onehot0", $onehot0(out), 1);
            chk("done_err_excl", done && err, 0);
            if (mon_active) begin
                if (out == '0) begin
                    ended      = 1'b1;
                    mon_active = 1'b0;
                    chk("pulse_len", hi_cnt, cur.len);
                    chk("done_at_end", done, cur.exp_done);
`ifdef DISPENSE_CNT_EN
                    chk("dispense_count", dispense_count, cur.exp_count);
`endif
                    $display("txn pulse out=%b accept_edge=%0d len=%0d done=%0b", cur.onehot, cur.e, hi_cnt, done);
                end else begin
                    chk("out_stable", out, cur.onehot);
                    hi_cnt++;
                    if (hi_cnt > P) begin
                        chk("pulse_overrun", hi_cnt, P);
                        mon_active = 1'b0;
                    end
                end
            end else if (out != '0) begin
                if (sb_q.size() == 0 || sb_q[0].is_err) begin
                    chk("unexpected_out", out, 0);
                end else begin
                    cur        = sb_q.pop_front();
                    mon_active = 1'b1;
                    hi_cnt     = 1;
                    chk("out_value", out, cur.onehot);
                    chk("pulse_start_edge", cyc, cur.e);
                end
            end
            if (done && !ended) chk("done_spurious", done, 0);
            if (err) begin
                if (sb_q.size() > 0 && sb_q[0].is_err) begin
                    eo = sb_q.pop_front();
                    chk("err_edge", cyc, eo.e);
                    chk("err_out_zero", out, 0);
                    $display("txn err accept_edge=%0d", eo.e);
                end else begin
                    chk("err_spurious", err, 0);
                end
            end
            if (!mon_active && sb_q.size() > 0 && cyc > sb_q[0].e) begin
                chk("response_edge", cyc, sb_q[0].e);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        ifc.req_valid = 1'b0;
        ifc.req_sel   = '0;
        ifc.abort     = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_out", out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_ready", ifc.req_ready, 1);
`ifdef DISPENSE_CNT_EN
        chk("reset_count", dispense_count, 0);
`endif
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single in-range dispense, full pulse and gap.
        tick(1'b1, 2, -1, 1'b0);
        idle(8);
        // Out-of-range index, then an immediate follow-up.
        tick(1'b1, 3, -1, 1'b0);
        tick(1'b1, 0, -1, 1'b0);
        idle(8);
        // Abort on the second ACTIVE cycle.
        tick(1'b1, 1, 1, 1'b0);
        idle(4);
        // Abort on the last ACTIVE cycle (coincides with expiry) and in the done cycle.
        tick(1'b1, 0, P - 1, 1'b0);
        idle(3);
        tick(1'b1, 2, P, 1'b0);
        idle(3);
        // Abort while idle blocks acceptance.
        tick(1'b1, 1, -1, 1'b1);
        idle(8);
        // req_valid held with changing index across ACTIVE/GAP.
        for (int i = 0; i < 16; i++) tick(1'b1, (i % 2 == 0) ? 1 : 2, -1, 1'b0);
        idle(8);
        // Asynchronous reset in the middle of a pulse.
        tick(1'b1, 2, -1, 1'b0);
        idle(2);
        async_reset();
        tick(1'b1, 1, -1, 1'b0);
        idle(8);
        // Five back-to-back completed dispenses exercise counter saturation.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, i % NUM_ITEMS, -1, 1'b0);
            idle(P + G);
        end
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            int ab_off;
            ab_off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, P + G - 1)) : -1;
            tick($urandom_range(0, 9) < 7, int'($urandom_range(0, 3)), ab_off, $urandom_range(0, 9) == 0);
        end
        idle(12);
        chk("queue_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
